// File: rtl/jpeg_dequant_if.sv
// Coefficient-RAM read port and dequantised output stream of jpeg_dequant.
// master = dequantiser side, slave = RAM model / sink side.
interface jpeg_dequant_if #(
   parameter int AW = 5
);
   logic          coef_rd_o;
   logic [AW-1:0] coef_addr_o;
   logic [31:0]   coef_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [31:0]   out_data_o;

   modport master (
      output coef_rd_o, coef_addr_o, out_valid_o, out_data_o,
      input  coef_data_i, out_ready_i
   );

   modport slave (
      input  coef_rd_o, coef_addr_o, out_valid_o, out_data_o,
      output coef_data_i, out_ready_i
   );
endinterface

// File: rtl/jpeg_dequant.sv
// Block dequantiser: reads 32 packed coefficient pairs, scales each by its
// quantisation-table entry with saturation, and streams the pairs out.
module jpeg_dequant #(
   parameter int COEF_W = 16,
   parameter int Q_W    = 8,
   parameter int NWORDS = 32,
   parameter int AW     = 5
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           sat_o,
   input  logic           qt_we_i,
   input  logic [5:0]     qt_adr_i,
   input  logic [Q_W-1:0] qt_dat_i,
   jpeg_dequant_if.master bus
);

   localparam int PW = COEF_W + Q_W + 1;
   localparam logic signed [PW-1:0] MAX_V = PW'((2 ** (COEF_W - 1)) - 1);
   localparam logic signed [PW-1:0] MIN_V = ~MAX_V;
   localparam logic [AW-1:0] K_LAST = AW'(NWORDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_OUT, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           k_q, k_d;
   logic                    out_valid_q, out_valid_d;
   logic [2*COEF_W-1:0]     out_data_q, out_data_d;
   logic                    sat_q, sat_d;
   logic [Q_W-1:0]          qt_q [64];
   logic [Q_W-1:0]          qt_d [64];

   logic signed [PW-1:0]    din_hi, din_lo, q_hi, q_lo, prod_hi, prod_lo;

   function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [PW-1:0] p);
      if (p > MAX_V)      sat_coef = MAX_V[COEF_W-1:0];
      else if (p < MIN_V) sat_coef = MIN_V[COEF_W-1:0];
      else                sat_coef = p[COEF_W-1:0];
   endfunction

   function automatic logic is_sat(input logic signed [PW-1:0] p);
      is_sat = (p > MAX_V) || (p < MIN_V);
   endfunction

   // signed coefficient x zero-extended unsigned table entry, full-width product
   always_comb begin
      din_hi  = PW'($signed(bus.coef_data_i[2*COEF_W-1:COEF_W]));
      din_lo  = PW'($signed(bus.coef_data_i[COEF_W-1:0]));
      q_hi    = $signed(PW'(qt_q[{k_q, 1'b0}]));
      q_lo    = $signed(PW'(qt_q[{k_q, 1'b1}]));
      prod_hi = din_hi * q_hi;
      prod_lo = din_lo * q_lo;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
         for (int i = 0; i < 64; i++) qt_q[i] <= Q_W'(1);
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_q       <= sat_d;
         for (int i = 0; i < 64; i++) qt_q[i] <= qt_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) state_d = S_READ;
         S_READ: state_d = S_WAIT;
         S_WAIT: state_d = S_OUT;
         S_OUT:  if (bus.out_ready_i) state_d = (k_q == K_LAST) ? S_DONE : S_READ;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o          = (state_q != S_IDLE);
      done_o          = (state_q == S_DONE);
      bus.coef_rd_o   = (state_q == S_READ);
      bus.coef_addr_o = k_q;
      bus.out_valid_o = out_valid_q;
      bus.out_data_o  = out_data_q;
      sat_o           = sat_q;
   end

   // table writes land before a same-cycle start is acted on, so the block sees them
   always_comb begin
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sat_d       = sat_q;
      for (int i = 0; i < 64; i++) qt_d[i] = qt_q[i];
      if (state_q == S_IDLE && qt_we_i) qt_d[qt_adr_i] = qt_dat_i;
      if (state_q == S_IDLE && start_i) sat_d = 1'b0;
      if (state_q == S_WAIT) begin
         out_data_d  = {sat_coef(prod_hi), sat_coef(prod_lo)};
         out_valid_d = 1'b1;
         if (is_sat(prod_hi) || is_sat(prod_lo)) sat_d = 1'b1;
      end
      if (state_q == S_OUT && bus.out_ready_i) begin
         out_valid_d = 1'b0;
         k_d         = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end
   end

endmodule
